hazard_scoreboard: RTL and testbench

Parametrised next-generation pipeline hazard unit for the RV32I core. It keeps its own shadow ID/EX and EX/MEM destination registers, replacing the ones previously fed in from the pipeline. It adds a pending-write scoreboard for variable-latency producers (image-coprocessor results, wait-stated loads), WAW/RAW stalls, stall-cause reporting and a stall-cycle counter. It sits beside the decode stage and drives the global STALL and FLUSH.

---
 rtl/hazard_scoreboard_pkg.sv | 27 ++
 rtl/hazard_scoreboard_if.sv | 46 ++++
 rtl/hazard_scoreboard_bank.sv | 56 +++++
 rtl/hazard_scoreboard.sv | 106 ++++++++++
 tb/tb_hazard_scoreboard.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard unit: stall cause codes and the shadow
// pipeline-stage record tracked beside decode.
package hazard_pkg;

    // Shadow stages hold rd zero-extended to this width so the record type
    // does not depend on the instantiating module's ADDR_W.
    localparam int SHADOW_RD_W = 8;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        LTU  = 3'd1,
        BR   = 3'd2,
        LBR  = 3'd3,
        RAW  = 3'd4,
        WAW  = 3'd5,
        FULL = 3'd6
    } stall_cause_e;

    typedef struct packed {
        logic [SHADOW_RD_W-1:0] rd;
        logic                   reg_write;
        logic                   mem_read;
    } shadow_stage_t;

    localparam shadow_stage_t BUBBLE = '0;

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode-side bundle between the pipeline (master) and the hazard unit (slave).
interface hazard_scoreboard_if #(
    parameter int ADDR_W   = 5,
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = 32
);
    localparam int PC_W = $clog2(MAX_PEND + 1);

    logic              PIPE_HOLD;
    logic              ID_VALID;
    logic [ADDR_W-1:0] ID_RS1;
    logic [ADDR_W-1:0] ID_RS2;
    logic [ADDR_W-1:0] ID_RD;
    logic              ID_USE_RS1;
    logic              ID_USE_RS2;
    logic              ID_REG_WRITE;
    logic              ID_MEM_READ;
    logic              ID_MEM_WRITE;
    logic              ID_LONG_OP;
    logic              ID_BRANCH;
    logic              ID_JUMPR;
    logic              ID_PC_SRC;
    logic              WB_LONG_VALID;
    logic [ADDR_W-1:0] WB_LONG_RD;
    logic              STALL;
    logic              FLUSH;
    logic [2:0]        STALL_CAUSE;
    logic [PC_W-1:0]   PEND_CNT;
    logic [CNT_W-1:0]  STALL_CYCLES;
    logic              ERR;

    modport master (
        output PIPE_HOLD, ID_VALID, ID_RS1, ID_RS2, ID_RD, ID_USE_RS1, ID_USE_RS2,
               ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE, ID_LONG_OP, ID_BRANCH,
               ID_JUMPR, ID_PC_SRC, WB_LONG_VALID, WB_LONG_RD,
        input  STALL, FLUSH, STALL_CAUSE, PEND_CNT, STALL_CYCLES, ERR
    );

    modport slave (
        input  PIPE_HOLD, ID_VALID, ID_RS1, ID_RS2, ID_RD, ID_USE_RS1, ID_USE_RS2,
               ID_REG_WRITE, ID_MEM_READ, ID_MEM_WRITE, ID_LONG_OP, ID_BRANCH,
               ID_JUMPR, ID_PC_SRC, WB_LONG_VALID, WB_LONG_RD,
        output STALL, FLUSH, STALL_CAUSE, PEND_CNT, STALL_CYCLES, ERR
    );

endinterface

// File: rtl/hazard_scoreboard_bank.sv
// Pending-write bank for variable-latency producers: one bit per register,
// an outstanding-op count and a sticky error for stray writebacks.
module scoreboard_bank #(
    parameter  int NUM_REGS = 32,
    parameter  int ADDR_W   = 5,
    parameter  int MAX_PEND = 4,
    localparam int PC_W     = $clog2(MAX_PEND + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_valid,
    input  logic [ADDR_W-1:0] set_rd,
    input  logic              clr_valid,
    input  logic [ADDR_W-1:0] clr_rd,
    input  logic [ADDR_W-1:0] rd_rs1,
    input  logic [ADDR_W-1:0] rd_rs2,
    input  logic [ADDR_W-1:0] rd_rd,
    output logic              pend_rs1,
    output logic              pend_rs2,
    output logic              pend_rd,
    output logic [PC_W-1:0]   pend_cnt,
    output logic              err
);
    logic [NUM_REGS-1:0] pending;
    logic                set_ok;
    logic                clr_hit;

    always_comb begin
        set_ok   = set_valid & (set_rd != '0);
        clr_hit  = clr_valid & (clr_rd != '0) & pending[clr_rd];
        pend_rs1 = pending[rd_rs1];
        pend_rs2 = pending[rd_rs2];
        pend_rd  = pending[rd_rd];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= '0;
            pend_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (clr_hit)
                pending[clr_rd] <= 1'b0;
            // Set is assigned last so it wins when both target one register.
            if (set_ok)
                pending[set_rd] <= 1'b1;
            if (set_ok && !clr_hit)
                pend_cnt <= pend_cnt + PC_W'(1);
            else if (clr_hit && !set_ok)
                pend_cnt <= pend_cnt - PC_W'(1);
            if (clr_valid && !clr_hit)
                err <= 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-side hazard unit: shadow ID/EX and EX/MEM destinations, long-op
// scoreboard, prioritised stall causes, flush and a saturating stall counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int ADDR_W    = 5,
    parameter int MAX_PEND  = 4,
    parameter int CNT_W     = 32,
    parameter int STORE_FWD = 1
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave bus
);
    localparam int PC_W = $clog2(MAX_PEND + 1);

    shadow_stage_t    id_ex;
    shadow_stage_t    ex_mem;
    logic [PC_W-1:0]  pend_cnt;
    logic             pend_rs1, pend_rs2, pend_rd;
    logic             ctrl, rs2_ltu, ltu, br, lbr, raw, waw, full;
    logic             stall, issue;
    stall_cause_e     cause;
    logic [CNT_W-1:0] stall_cycles;

    function automatic logic hit(input logic [ADDR_W-1:0] r, input shadow_stage_t s);
        return (r != '0) && (SHADOW_RD_W'(r) == s.rd);
    endfunction

    always_comb begin
        ctrl    = bus.ID_BRANCH | bus.ID_JUMPR;
        rs2_ltu = bus.ID_USE_RS2 & hit(bus.ID_RS2, id_ex)
                  & ~((STORE_FWD != 0) & bus.ID_MEM_WRITE);
        ltu     = bus.ID_VALID & id_ex.mem_read
                  & ((bus.ID_USE_RS1 & hit(bus.ID_RS1, id_ex)) | rs2_ltu);
        br      = bus.ID_VALID & ctrl & id_ex.reg_write
                  & (hit(bus.ID_RS1, id_ex) | (~bus.ID_JUMPR & hit(bus.ID_RS2, id_ex)));
        lbr     = bus.ID_VALID & ctrl & ex_mem.mem_read
                  & (hit(bus.ID_RS1, ex_mem) | (~bus.ID_JUMPR & hit(bus.ID_RS2, ex_mem)));
        raw     = bus.ID_VALID & ((bus.ID_USE_RS1 & pend_rs1) | (bus.ID_USE_RS2 & pend_rs2));
        waw     = bus.ID_VALID & bus.ID_REG_WRITE & pend_rd;
        full    = bus.ID_VALID & bus.ID_LONG_OP & (pend_cnt == PC_W'(MAX_PEND));
        stall   = ltu | br | lbr | raw | waw | full;
        issue   = bus.ID_VALID & ~stall & ~bus.PIPE_HOLD;

        cause = NONE;
        if (ltu)       cause = LTU;
        else if (br)   cause = BR;
        else if (lbr)  cause = LBR;
        else if (raw)  cause = RAW;
        else if (waw)  cause = WAW;
        else if (full) cause = FULL;
    end

    assign bus.STALL        = stall;
    assign bus.STALL_CAUSE  = cause;
    assign bus.FLUSH        = bus.ID_VALID & bus.ID_PC_SRC & ~stall;
    assign bus.PEND_CNT     = pend_cnt;
    assign bus.STALL_CYCLES = stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_ex  <= BUBBLE;
            ex_mem <= BUBBLE;
        end else if (!bus.PIPE_HOLD) begin
            ex_mem <= id_ex;
            if (issue) begin
                id_ex.rd        <= SHADOW_RD_W'(bus.ID_RD);
                id_ex.reg_write <= bus.ID_REG_WRITE & ~bus.ID_LONG_OP;
                id_ex.mem_read  <= bus.ID_MEM_READ & ~bus.ID_LONG_OP;
            end else begin
                id_ex <= BUBBLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cycles <= '0;
        else if (stall && bus.ID_VALID && !bus.PIPE_HOLD && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
    end

    scoreboard_bank #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .MAX_PEND (MAX_PEND)
    ) u_bank (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_valid (issue & bus.ID_LONG_OP),
        .set_rd    (bus.ID_RD),
        .clr_valid (bus.WB_LONG_VALID),
        .clr_rd    (bus.WB_LONG_RD),
        .rd_rs1    (bus.ID_RS1),
        .rd_rs2    (bus.ID_RS2),
        .rd_rd     (bus.ID_RD),
        .pend_rs1  (pend_rs1),
        .pend_rs2  (pend_rs2),
        .pend_rd   (pend_rd),
        .pend_cnt  (pend_cnt),
        .err       (bus.ERR)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed plan sequences with literal
// expectations, then random traffic checked every cycle against a model.
module tb_hazard_scoreboard;
    localparam int ADDR_W   = 5;
    localparam int MAX_PEND = 4;
    localparam int CNT_W    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.ADDR_W(ADDR_W), .MAX_PEND(MAX_PEND), .CNT_W(CNT_W)) bus();

    hazard_scoreboard #(
        .NUM_REGS (32),
        .ADDR_W   (ADDR_W),
        .MAX_PEND (MAX_PEND),
        .CNT_W    (CNT_W),
        .STORE_FWD(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Model: the last two issued instructions (most recent first), the set of
    // registers awaiting a long-op result, sticky error and stall count.
    int     ex_rd,  mem_rd;
    bit     ex_ld,  ex_wr, mem_ld;
    bit     pend[32];
    bit     err_m;
    longint scyc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int outstanding();
        int n = 0;
        for (int r = 0; r < 32; r++) n += pend[r] ? 1 : 0;
        return n;
    endfunction

    function automatic bit same(input int r, input int d);
        return (r != 0) && (r == d);
    endfunction

    function automatic int exp_cause();
        int rs1 = int'(bus.ID_RS1);
        int rs2 = int'(bus.ID_RS2);
        int rd  = int'(bus.ID_RD);
        bit cf  = bus.ID_BRANCH || bus.ID_JUMPR;
        if (!bus.ID_VALID) return 0;
        if (ex_ld && ((bus.ID_USE_RS1 && same(rs1, ex_rd)) ||
                      (bus.ID_USE_RS2 && !bus.ID_MEM_WRITE && same(rs2, ex_rd)))) return 1;
        if (cf && ex_wr && (same(rs1, ex_rd) || (!bus.ID_JUMPR && same(rs2, ex_rd)))) return 2;
        if (cf && mem_ld && (same(rs1, mem_rd) || (!bus.ID_JUMPR && same(rs2, mem_rd)))) return 3;
        if ((bus.ID_USE_RS1 && pend[rs1]) || (bus.ID_USE_RS2 && pend[rs2])) return 4;
        if (bus.ID_REG_WRITE && pend[rd]) return 5;
        if (bus.ID_LONG_OP && outstanding() == MAX_PEND) return 6;
        return 0;
    endfunction

    task automatic model_reset();
        ex_rd = 0; mem_rd = 0; ex_ld = 0; ex_wr = 0; mem_ld = 0;
        for (int r = 0; r < 32; r++) pend[r] = 0;
        err_m = 0; scyc = 0;
    endtask

    task automatic model_step();
        int c     = exp_cause();
        bit hold  = bus.PIPE_HOLD;
        bit issue = bus.ID_VALID && (c == 0) && !hold;
        int rd    = int'(bus.ID_RD);
        int wbrd  = int'(bus.WB_LONG_RD);
        bit wbhit = bus.WB_LONG_VALID && wbrd != 0 && pend[wbrd];
        if (bus.WB_LONG_VALID && !wbhit) err_m = 1;
        if (wbhit) pend[wbrd] = 0;
        if (issue && bus.ID_LONG_OP && rd != 0) pend[rd] = 1;
        if (c != 0 && !hold && scyc != 64'hFFFF_FFFF) scyc++;
        if (!hold) begin
            mem_rd = ex_rd; mem_ld = ex_ld;
            ex_rd  = issue ? rd : 0;
            ex_wr  = issue && bus.ID_REG_WRITE && !bus.ID_LONG_OP;
            ex_ld  = issue && bus.ID_MEM_READ && !bus.ID_LONG_OP;
        end
    endtask

    task automatic sample();
        int c;
        @(negedge clk);
        c = exp_cause();
        chk("stall",  bus.STALL, (c != 0));
        chk("cause",  bus.STALL_CAUSE, c);
        chk("flush",  bus.FLUSH, bus.ID_VALID && bus.ID_PC_SRC && c == 0);
        chk("pend",   bus.PEND_CNT, outstanding());
        chk("scyc",   bus.STALL_CYCLES, scyc);
        chk("err",    bus.ERR, err_m);
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input int rs1, input int rs2, input int rd,
                         input bit u1, input bit u2, input bit wr, input bit mr,
                         input bit mw, input bit lg, input bit br, input bit jr, input bit pc);
        bus.ID_VALID = v;     bus.ID_RS1 = ADDR_W'(rs1); bus.ID_RS2 = ADDR_W'(rs2);
        bus.ID_RD = ADDR_W'(rd); bus.ID_USE_RS1 = u1; bus.ID_USE_RS2 = u2;
        bus.ID_REG_WRITE = wr; bus.ID_MEM_READ = mr; bus.ID_MEM_WRITE = mw;
        bus.ID_LONG_OP = lg;  bus.ID_BRANCH = br; bus.ID_JUMPR = jr; bus.ID_PC_SRC = pc;
    endtask

    task automatic idle();                         drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic alu(input int rd, rs1, rs2);    drive(1, rs1, rs2, rd, 1, 1, 1, 0, 0, 0, 0, 0, 0); endtask
    task automatic load(input int rd, rs1);        drive(1, rs1, 0, rd, 1, 0, 1, 1, 0, 0, 0, 0, 0); endtask
    task automatic store(input int rs1, rs2);      drive(1, rs1, rs2, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0); endtask
    task automatic longop(input int rd);           drive(1, 0, 0, rd, 0, 0, 1, 0, 0, 1, 0, 0, 0); endtask
    task automatic beq(input int rs1, rs2);        drive(1, rs1, rs2, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1); endtask
    task automatic wb(input bit v, input int rd);
        bus.WB_LONG_VALID = v; bus.WB_LONG_RD = ADDR_W'(rd);
    endtask

    initial begin
        bus.PIPE_HOLD = 0;
        idle();
        wb(0, 0);
        model_reset();

        // Reset state
        @(negedge clk);
        chk("rst_stall", bus.STALL, 0);
        chk("rst_cause", bus.STALL_CAUSE, 0);
        chk("rst_pend",  bus.PEND_CNT, 0);
        chk("rst_scyc",  bus.STALL_CYCLES, 0);
        chk("rst_err",   bus.ERR, 0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: load-to-use
        load(5, 1);        sample(); chk("t1_lw",   bus.STALL, 0); advance();
        alu(6, 5, 1);      sample(); chk("t1_ltu",  bus.STALL_CAUSE, 1); advance();
                           sample(); chk("t1_go",   bus.STALL, 0); advance();
        idle();            sample(); advance();

        // 2: store data exempt, store address not
        load(5, 1);        sample(); advance();
        store(2, 5);       sample(); chk("t2_sw_rs2", bus.STALL, 0); advance();
        load(5, 1);        sample(); advance();
        store(5, 2);       sample(); chk("t2_sw_rs1", bus.STALL, 1); advance();
        idle();            sample(); advance();

        // 3: long-op RAW until the cycle after writeback
        longop(7);         sample(); chk("t3_pend0", bus.PEND_CNT, 0); advance();
        alu(8, 7, 0);      sample(); chk("t3_raw",   bus.STALL_CAUSE, 4);
                                     chk("t3_pend1", bus.PEND_CNT, 1); advance();
        wb(1, 7);          sample(); chk("t3_wbcyc", bus.STALL, 1); advance();
        wb(0, 0);          sample(); chk("t3_go",    bus.STALL, 0);
                                     chk("t3_pend",  bus.PEND_CNT, 0); advance();
        idle();            sample(); advance();

        // 4: scoreboard full
        for (int r = 1; r <= 4; r++) begin longop(r); sample(); advance(); end
        longop(10);        sample(); chk("t4_full",  bus.STALL_CAUSE, 6);
                                     chk("t4_pend4", bus.PEND_CNT, 4); advance();
        wb(1, 2);          sample(); chk("t4_wbcyc", bus.STALL, 1); advance();
        wb(0, 0);          sample(); chk("t4_go",    bus.STALL, 0);
                                     chk("t4_pend3", bus.PEND_CNT, 3); advance();
        idle();
        for (int i = 0; i < 4; i++) begin
            wb(1, (i == 0) ? 1 : (i == 1) ? 3 : (i == 2) ? 4 : 10);
            sample(); advance();
        end
        wb(0, 0);          sample(); chk("t4_drain", bus.PEND_CNT, 0); advance();

        // 5: taken branch flush vs branch hazard
        beq(0, 0);         sample(); chk("t5_flush", bus.FLUSH, 1); advance();
        drive(1, 1, 0, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0); sample(); advance();
        beq(3, 0);         sample(); chk("t5_noflush", bus.FLUSH, 0);
                                     chk("t5_br",      bus.STALL_CAUSE, 2); advance();
        idle();            sample(); advance();

        // 6: stray writeback, then async reset in the middle of a stall
        wb(1, 9);          sample(); chk("t6_err0", bus.ERR, 0); advance();
        wb(0, 0);          sample(); chk("t6_err1", bus.ERR, 1); advance();
                           sample(); chk("t6_sticky", bus.ERR, 1); advance();
        load(5, 1);        sample(); advance();
        alu(6, 5, 1);      sample(); chk("t6_stall", bus.STALL, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_stall", bus.STALL, 0);
        chk("ar_cause", bus.STALL_CAUSE, 0);
        chk("ar_flush", bus.FLUSH, 0);
        chk("ar_pend",  bus.PEND_CNT, 0);
        chk("ar_scyc",  bus.STALL_CYCLES, 0);
        chk("ar_err",   bus.ERR, 0);
        model_reset();
        #2 rst_n = 1'b1;
        advance();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            int plist[$];
            bit lg = ($urandom_range(0, 99) < 15);
            bit mr = !lg && ($urandom_range(0, 99) < 25);
            bit mw = !lg && !mr && ($urandom_range(0, 99) < 20);
            bit brn = !lg && !mr && !mw && ($urandom_range(0, 99) < 20);
            bit jr = !lg && !mr && !mw && !brn && ($urandom_range(0, 99) < 10);
            drive($urandom_range(0, 99) < 85,
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  lg || mr || (!mw && !brn && $urandom_range(0, 1)),
                  mr, mw, lg, brn, jr, (brn || jr) && $urandom_range(0, 1));
            bus.PIPE_HOLD = ($urandom_range(0, 99) < 10);
            for (int r = 1; r < 32; r++) if (pend[r]) plist.push_back(r);
            if (plist.size() > 0 && $urandom_range(0, 99) < 35)
                wb(1, plist[$urandom_range(0, plist.size() - 1)]);
            else if ($urandom_range(0, 999) < 5)
                wb(1, $urandom_range(0, 31));
            else
                wb(0, 0);
            sample();
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
